// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Read hits return combinationally; fills and all stores go through a registered req/ack memory port.
module data_cache #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int CACHE_SIZE    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic                     we,
  input  logic                     ByteOp,
  input  logic [ADDRESS_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0]    WriteData,
  output logic [DATA_WIDTH-1:0]    ReadData,
  output logic                     stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_byte,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int IDX   = $clog2(CACHE_SIZE);
  localparam int TAG_W = ADDRESS_WIDTH - IDX - 2;
  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t                   state_q, state_d;
  logic [CACHE_SIZE-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]         tag_q  [CACHE_SIZE];
  logic [DATA_WIDTH-1:0]    data_q [CACHE_SIZE];
  logic                     mem_req_q, mem_req_d;
  logic                     mem_we_q, mem_we_d;
  logic                     mem_byte_q, mem_byte_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [31:0]              hit_count_q, hit_count_d;
  logic [31:0]              miss_count_q, miss_count_d;

  logic                     line_we;
  logic [IDX-1:0]           line_idx;
  logic [TAG_W-1:0]         line_tag;
  logic [DATA_WIDTH-1:0]    line_data;
  logic [IDX-1:0]           cpu_idx;
  logic [TAG_W-1:0]         cpu_tag;
  logic                     hit;

  // Big-endian lanes: byte offset 0 is the most significant byte of the word.
  function automatic logic [BYTE_WIDTH-1:0] get_lane(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [1:0] off);
    get_lane = w[(BYTES-1-int'(off))*BYTE_WIDTH +: BYTE_WIDTH];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_lane(input logic [DATA_WIDTH-1:0] w,
                                                       input logic [1:0] off,
                                                       input logic [BYTE_WIDTH-1:0] b);
    merge_lane = w;
    merge_lane[(BYTES-1-int'(off))*BYTE_WIDTH +: BYTE_WIDTH] = b;
  endfunction

  assign cpu_idx = Address[IDX+1:2];
  assign cpu_tag = Address[ADDRESS_WIDTH-1:IDX+2];
  assign hit     = (state_q == IDLE) && req && !we && valid_q[cpu_idx] &&
                   (tag_q[cpu_idx] == cpu_tag);

  always_comb begin
    ReadData = '0;
    if (hit) begin
      ReadData = ByteOp ? {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, get_lane(data_q[cpu_idx], Address[1:0])}
                        : data_q[cpu_idx];
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_byte_d   = mem_byte_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    stall        = 1'b0;
    line_we      = 1'b0;
    line_idx     = mem_addr_q[IDX+1:2];
    line_tag     = mem_addr_q[ADDRESS_WIDTH-1:IDX+2];
    line_data    = mem_rdata;
    case (state_q)
      IDLE: begin
        if (hit) begin
          if (hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
        end else if (req && !we) begin
          stall      = 1'b1;
          state_d    = FILL;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_byte_d = 1'b0;
          mem_addr_d = {Address[ADDRESS_WIDTH-1:2], 2'b00};
          if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
        end else if (req) begin
          stall       = 1'b1;
          state_d     = WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_byte_d  = ByteOp;
          mem_addr_d  = Address;
          mem_wdata_d = WriteData;
        end
      end
      FILL: begin
        stall = 1'b1;
        if (mem_ack) begin
          line_we           = 1'b1;
          valid_d[line_idx] = 1'b1;
          mem_req_d         = 1'b0;
          state_d           = IDLE;
        end
      end
      WRITE: begin
        stall = 1'b1;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          // Write-through only refreshes a line that is already resident.
          if (valid_q[line_idx] && (tag_q[line_idx] == line_tag)) begin
            line_we   = 1'b1;
            line_data = mem_byte_q ? merge_lane(data_q[line_idx], mem_addr_q[1:0],
                                                mem_wdata_q[BYTE_WIDTH-1:0])
                                   : mem_wdata_q;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_byte_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_byte_q   <= mem_byte_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data storage carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_data;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_byte   = mem_byte_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
